// File: rtl/gpu_rect_engine_if.sv
// Op type shared with the cpu, plus the engine's op / sprite-ROM / framebuffer bus bundle.
// The engine takes the slave side; the cpu, ROM and framebuffer controller take the master side.
package gpu_rect_pkg;
  localparam int GPU_COLOR_W    = 12;
  localparam int GPU_MEM_ADDR_W = 16;

  typedef struct packed {
    logic [10:0]               x;
    logic [10:0]               y;
    logic [10:0]               width;
    logic [10:0]               height;
    logic [GPU_COLOR_W-1:0]    color;
    logic                      mem_en;
    logic [GPU_MEM_ADDR_W-1:0] mem_addr;
    logic                      scale;
  } gpu_op_t;
endpackage

interface gpu_rect_engine_if #(
  parameter int FB_ADDR_W = 19
) ();
  import gpu_rect_pkg::*;

  gpu_op_t                   op;
  logic                      op_valid;
  logic                      op_ready;
  logic [GPU_MEM_ADDR_W-1:0] mem_rd_addr;
  logic                      mem_rd_en;
  logic [GPU_COLOR_W-1:0]    mem_rd_data;
  logic [FB_ADDR_W-1:0]      fb_addr;
  logic [GPU_COLOR_W-1:0]    fb_data;
  logic                      fb_we;
  logic                      fb_ready;

  modport slave (
    input  op, op_valid, mem_rd_data, fb_ready,
    output op_ready, mem_rd_addr, mem_rd_en, fb_addr, fb_data, fb_we
  );

  modport master (
    output op, op_valid, mem_rd_data, fb_ready,
    input  op_ready, mem_rd_addr, mem_rd_en, fb_addr, fb_data, fb_we
  );
endinterface

// File: rtl/gpu_rect_engine.sv
// Rasterises one rectangle op at a time into the framebuffer, solid fill or sprite texels,
// with 2x zoom, transparency skip and screen clipping; fb writes are held until fb_ready.
module gpu_rect_engine
  import gpu_rect_pkg::*;
#(
  parameter int                  HOR_ACTIVE_PIXELS = 640,
  parameter int                  VER_ACTIVE_PIXELS = 480,
  parameter int                  COLOR_W           = GPU_COLOR_W,
  parameter int                  MEM_ADDR_W        = GPU_MEM_ADDR_W,
  parameter int                  FB_ADDR_W         = 19,
  parameter logic [COLOR_W-1:0]  TRANSPARENT_COLOR = 12'hF0F
) (
  input  logic             clk,
  input  logic             rst,
  gpu_rect_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, FETCH, WRITE} state_t;

  state_t                state_q, state_d;
  logic                  op_ready_q, op_ready_d;
  logic [10:0]           x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [COLOR_W-1:0]    color_q, color_d;
  logic                  scale_q, scale_d;
  logic                  empty_q, empty_d;
  logic [11:0]           px_q, px_d, py_q, py_d;
  logic [FB_ADDR_W-1:0]  fb_row_q, fb_row_d;
  logic [MEM_ADDR_W-1:0] tex_row_q, tex_row_d;
  logic [COLOR_W-1:0]    texel_q, texel_d;
  logic                  stall_q, stall_d;

  logic [11:0]           dw, dh, tex_col;
  logic [12:0]           sx, sy;
  logic                  clipped, last_px, last_py, advance;
  logic [COLOR_W-1:0]    texel;
  logic [FB_ADDR_W-1:0]  fb_addr_o;
  logic [COLOR_W-1:0]    fb_data_o;
  logic                  fb_we_o, mem_rd_en_o;
  logic [MEM_ADDR_W-1:0] mem_rd_addr_o;

  assign dw      = {1'b0, w_q} << scale_q;
  assign dh      = {1'b0, h_q} << scale_q;
  // 13-bit destination so x + px never wraps back onto the screen
  assign sx      = 13'(x_q) + 13'(px_q);
  assign sy      = 13'(y_q) + 13'(py_q);
  assign clipped = (sx >= 13'(HOR_ACTIVE_PIXELS)) || (sy >= 13'(VER_ACTIVE_PIXELS));
  assign last_px = (px_q == dw - 12'd1);
  assign last_py = (py_q == dh - 12'd1);
  assign tex_col = scale_q ? (px_q >> 1) : px_q;
  // ROM data is only valid the cycle after the strobe; a stalled write replays the captured copy
  assign texel   = stall_q ? texel_q : bus.mem_rd_data;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    w_d           = w_q;
    h_d           = h_q;
    color_d       = color_q;
    scale_d       = scale_q;
    empty_d       = empty_q;
    px_d          = px_q;
    py_d          = py_q;
    fb_row_d      = fb_row_q;
    tex_row_d     = tex_row_q;
    texel_d       = texel_q;
    stall_d       = stall_q;
    advance       = 1'b0;
    fb_we_o       = 1'b0;
    fb_addr_o     = '0;
    fb_data_o     = '0;
    mem_rd_en_o   = 1'b0;
    mem_rd_addr_o = '0;

    case (state_q)
      IDLE: begin
        if (bus.op_valid && op_ready_q) begin
          x_d       = bus.op.x;
          y_d       = bus.op.y;
          w_d       = bus.op.width;
          h_d       = bus.op.height;
          color_d   = bus.op.color;
          scale_d   = bus.op.scale;
          empty_d   = (bus.op.width == 11'd0) || (bus.op.height == 11'd0);
          px_d      = '0;
          py_d      = '0;
          stall_d   = 1'b0;
          fb_row_d  = FB_ADDR_W'(bus.op.y) * FB_ADDR_W'(HOR_ACTIVE_PIXELS);
          tex_row_d = bus.op.mem_addr;
          state_d   = (empty_d || !bus.op.mem_en) ? FILL : FETCH;
        end
      end
      FILL: begin
        if (empty_q) begin
          state_d = IDLE;
        end else begin
          fb_we_o   = !clipped;
          fb_addr_o = fb_row_q + FB_ADDR_W'(sx);
          fb_data_o = color_q;
          advance   = clipped || bus.fb_ready;
        end
      end
      FETCH: begin
        mem_rd_en_o   = 1'b1;
        mem_rd_addr_o = tex_row_q + MEM_ADDR_W'(tex_col);
        stall_d       = 1'b0;
        state_d       = WRITE;
      end
      WRITE: begin
        texel_d = texel;
        if (clipped || texel == TRANSPARENT_COLOR) begin
          advance = 1'b1;
        end else begin
          fb_we_o   = 1'b1;
          fb_addr_o = fb_row_q + FB_ADDR_W'(sx);
          fb_data_o = texel;
          advance   = bus.fb_ready;
        end
        stall_d = !advance;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (last_px) begin
        px_d     = '0;
        py_d     = py_q + 12'd1;
        fb_row_d = fb_row_q + FB_ADDR_W'(HOR_ACTIVE_PIXELS);
        // zoomed sprites reuse each texel row for two screen rows
        if (!scale_q || py_q[0]) tex_row_d = tex_row_q + MEM_ADDR_W'(w_q);
      end else begin
        px_d = px_q + 12'd1;
      end
      if (last_px && last_py) state_d = IDLE;
      else if (state_q == WRITE) state_d = FETCH;
    end

    op_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_ready_q <= 1'b1;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      scale_q    <= 1'b0;
      empty_q    <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      fb_row_q   <= '0;
      tex_row_q  <= '0;
      texel_q    <= '0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_ready_q <= op_ready_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      scale_q    <= scale_d;
      empty_q    <= empty_d;
      px_q       <= px_d;
      py_q       <= py_d;
      fb_row_q   <= fb_row_d;
      tex_row_q  <= tex_row_d;
      texel_q    <= texel_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.op_ready    = op_ready_q;
  assign bus.fb_we       = fb_we_o;
  assign bus.fb_addr     = fb_addr_o;
  assign bus.fb_data     = fb_data_o;
  assign bus.mem_rd_en   = mem_rd_en_o;
  assign bus.mem_rd_addr = mem_rd_addr_o;

endmodule

// File: tb/tb_gpu_rect_engine.sv
// Directed bench for gpu_rect_engine: fills, sprites, zoom, transparency, clipping,
// backpressure, busy-op rejection, empty ops and mid-op reset.
module tb_gpu_rect_engine;
  import gpu_rect_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpu_rect_engine_if #(.FB_ADDR_W(19)) bus ();
  gpu_rect_engine dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] rom [0:1023];
  logic [18:0] wa [$];
  logic [11:0] wd [$];
  logic [18:0] ea [$];
  logic [11:0] ed [$];
  logic        bp_mode = 1'b0;
  logic        stall_pend = 1'b0;
  logic [18:0] hold_a;
  logic [11:0] hold_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // sprite ROM: registered read, garbage on idle cycles so a stalled write must hold its texel
  always @(posedge clk)
    bus.mem_rd_data <= bus.mem_rd_en ? rom[bus.mem_rd_addr[9:0]] : 12'h555;

  always @(posedge clk) begin
    #1;
    if (bp_mode) bus.fb_ready = ($urandom_range(0, 9) >= 3);
  end

  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("stall_we", bus.fb_we, 1);
        chk("stall_addr", bus.fb_addr, hold_a);
        chk("stall_data", bus.fb_data, hold_d);
      end
      if (bus.fb_we && bus.fb_ready) begin
        wa.push_back(bus.fb_addr);
        wd.push_back(bus.fb_data);
      end
      stall_pend = bus.fb_we && !bus.fb_ready;
      hold_a     = bus.fb_addr;
      hold_d     = bus.fb_data;
    end
  end

  task automatic exp_build(input gpu_op_t o);
    int dw, dh, sx, sy, ta;
    logic [11:0] v;
    ea.delete();
    ed.delete();
    dw = int'(o.width) << o.scale;
    dh = int'(o.height) << o.scale;
    for (int py = 0; py < dh; py++) begin
      for (int px = 0; px < dw; px++) begin
        sx = int'(o.x) + px;
        sy = int'(o.y) + py;
        ta = (int'(o.mem_addr) + (py >> o.scale) * int'(o.width) + (px >> o.scale)) % 65536;
        v  = o.mem_en ? rom[ta % 1024] : o.color;
        if (sx < 640 && sy < 480 && !(o.mem_en && v == 12'hF0F)) begin
          ea.push_back(19'(sy * 640 + sx));
          ed.push_back(v);
        end
      end
    end
  endtask

  task automatic start_op(input gpu_op_t o);
    @(posedge clk); #1;
    chk("idle_ready", bus.op_ready, 1);
    bus.op       = o;
    bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    chk("ready_drop", bus.op_ready, 0);
  endtask

  task automatic wait_done(input int limit, input logic pulse, output int n);
    gpu_op_t alt;
    alt        = '0;
    alt.width  = 11'd4;
    alt.height = 11'd4;
    alt.color  = 12'hEEE;
    n = 0;
    while (!bus.op_ready && n < limit) begin
      @(posedge clk); #1;
      n++;
      bus.op_valid = 1'b0;
      if (pulse && n == 3) begin
        bus.op       = alt;
        bus.op_valid = 1'b1;
      end
    end
    bus.op_valid = 1'b0;
    chk("done_in_budget", bus.op_ready, 1);
  endtask

  task automatic run_op(input gpu_op_t o, input int limit, input logic pulse, output int n);
    wa.delete();
    wd.delete();
    exp_build(o);
    start_op(o);
    wait_done(limit, pulse, n);
    @(negedge clk);
  endtask

  task automatic cmp_writes(input string tag);
    chk({tag, "_count"}, wa.size(), ea.size());
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      chk({tag, "_addr"}, wa[i], ea[i]);
      chk({tag, "_data"}, wd[i], ed[i]);
      if (wa[i] !== ea[i] || wd[i] !== ed[i]) break;
    end
  endtask

  initial begin
    gpu_op_t o;
    int      n;
    int      hist [816];
    int      pre;

    for (int i = 0; i < 1024; i++) rom[i] = 12'(i);
    rom[1000] = 12'h001;
    rom[1001] = 12'hF0F;
    rom[1002] = 12'h003;
    rom[1003] = 12'hF0F;

    rst          = 1'b1;
    bus.op       = '0;
    bus.op_valid = 1'b0;
    bus.fb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_op_ready", bus.op_ready, 1);
    chk("rst_fb_we", bus.fb_we, 0);
    chk("rst_mem_rd_en", bus.mem_rd_en, 0);
    chk("rst_fb_addr", bus.fb_addr, 0);
    chk("rst_fb_data", bus.fb_data, 0);
    chk("rst_mem_rd_addr", bus.mem_rd_addr, 0);
    rst = 1'b0;

    // two full-width rows of clear: one pixel per cycle, sequential addresses
    o = '0;
    o.width  = 11'd640;
    o.height = 11'd2;
    run_op(o, 3000, 1'b0, n);
    chk("clear_cycles", n, 1280);
    cmp_writes("clear");

    // 2x zoomed sprite
    o = '0;
    o.x = 11'd20; o.y = 11'd228; o.width = 11'd34; o.height = 11'd24;
    o.mem_en = 1'b1; o.mem_addr = 16'd0; o.scale = 1'b1;
    run_op(o, 10000, 1'b0, n);
    chk("sprite_cycles", n, 6528);
    cmp_writes("sprite");
    chk("sprite_px35_addr", (wa.size() > 343) ? 32'(wa[343]) : 32'hFFFF_FFFF, 233 * 640 + 23);
    chk("sprite_px35_data", (wd.size() > 343) ? 32'(wd[343]) : 32'hFFFF_FFFF, 69);
    foreach (hist[i]) hist[i] = 0;
    foreach (wd[i]) if (wd[i] < 12'd816) hist[wd[i]]++;
    for (int i = 0; i < 816; i++) begin
      chk("texel_x4", hist[i], 4);
      if (hist[i] != 4) break;
    end

    // transparency: only texels 1 and 3 land
    o = '0;
    o.x = 11'd100; o.y = 11'd10; o.width = 11'd4; o.height = 11'd1;
    o.mem_en = 1'b1; o.mem_addr = 16'd1000;
    run_op(o, 100, 1'b0, n);
    chk("transp_cycles", n, 8);
    chk("transp_count", wa.size(), 2);
    chk("transp_a0", (wa.size() > 0) ? 32'(wa[0]) : 32'hFFFF_FFFF, 6500);
    chk("transp_d0", (wd.size() > 0) ? 32'(wd[0]) : 32'hFFFF_FFFF, 1);
    chk("transp_a1", (wa.size() > 1) ? 32'(wa[1]) : 32'hFFFF_FFFF, 6502);
    chk("transp_d1", (wd.size() > 1) ? 32'(wd[1]) : 32'hFFFF_FFFF, 3);

    // clipping at the bottom-right corner
    o = '0;
    o.x = 11'd630; o.y = 11'd475; o.width = 11'd20; o.height = 11'd10; o.color = 12'hABC;
    run_op(o, 1000, 1'b0, n);
    chk("clip_cycles", n, 200);
    chk("clip_count", wa.size(), 50);
    cmp_writes("clip");

    // 5x3 fill, first with fb_ready held high, then under random stalls with a busy op pulse
    o = '0;
    o.x = 11'd4; o.y = 11'd2; o.width = 11'd5; o.height = 11'd3; o.color = 12'h5A3;
    run_op(o, 200, 1'b0, n);
    chk("fill_cycles", n, 15);
    cmp_writes("fill_rdy");
    bp_mode = 1'b1;
    run_op(o, 2000, 1'b1, n);
    cmp_writes("fill_bp");
    bp_mode = 1'b0;
    @(posedge clk); #1;
    bus.fb_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("busy_op_ignored", wa.size(), 15);
    chk("idle_after_bp", bus.op_ready, 1);

    // empty ops
    o = '0;
    o.height = 11'd5;
    o.color  = 12'h777;
    run_op(o, 50, 1'b0, n);
    chk("w0_cycles", n, 1);
    chk("w0_writes", wa.size(), 0);
    o = '0;
    o.width  = 11'd3;
    o.mem_en = 1'b1;
    run_op(o, 50, 1'b0, n);
    chk("h0_cycles", n, 1);
    chk("h0_writes", wa.size(), 0);

    // reset in the middle of a sprite
    o = '0;
    o.x = 11'd20; o.y = 11'd228; o.width = 11'd34; o.height = 11'd24;
    o.mem_en = 1'b1; o.scale = 1'b1;
    wa.delete();
    wd.delete();
    start_op(o);
    repeat (100) @(posedge clk);
    #1;
    chk("busy_before_rst", bus.fb_we | bus.mem_rd_en, 1);
    pre = wa.size();
    rst = 1'b1;
    #1;
    chk("rst_mid_fb_we", bus.fb_we, 0);
    chk("rst_mid_mem_rd_en", bus.mem_rd_en, 0);
    chk("rst_mid_op_ready", bus.op_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_writes", wa.size(), pre);
    chk("rst_idle", bus.op_ready, 1);

    o = '0;
    o.x = 11'd100; o.y = 11'd10; o.width = 11'd4; o.height = 11'd1;
    o.mem_en = 1'b1; o.mem_addr = 16'd1000;
    run_op(o, 100, 1'b0, n);
    chk("post_rst_cycles", n, 8);
    cmp_writes("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
